// File: rtl/sdram_stream_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_stream_scheduler
//
// Shares one SDRAM between three requesters:
//   - the incoming stream writer (one full burst per request),
//   - the refill path that tops up the FTDI-side FIFO,
//   - periodic refresh.
// The SDRAM is used as a ring buffer of fixed-size bursts. Write pointer,
// read pointer and fill level are all counted in bursts. One burst command
// is issued to the SDRAM command engine at a time, and it is held until the
// engine reports cmd_done.
//
// Optional feature macro: SDRAM_SCHED_READ_PRIORITY_EN
//   defined   : when a write and a read are both eligible, READ always wins
//               (refresh is still highest), so the FTDI path stays fed.
//   undefined : write and read alternate round-robin when both are eligible.
//
// Ports:
//   sdram_clk     in   single clock for all logic
//   reset_n       in   asynchronous active-low reset
//   refresh_req   in   level, refresh is due
//   refresh_ack   out  pulse on the cmd_done cycle of a refresh
//   wr_req        in   level, source holds one full burst
//   wr_grant      out  high for the whole write burst
//   wr_stall      out  ring full, source must hold its data
//   fifo_wrusedw  in   FIFO write-side used words
//   cmd_valid     out  command request to the SDRAM engine
//   cmd_op        out  01 write, 10 read, 11 refresh, 00 idle
//   cmd_addr      out  burst index of the current command
//   cmd_done      in   one-cycle pulse, current command finished
//   ring_level    out  bursts stored in the ring
//   busy          out  a command is in progress
// -----------------------------------------------------------------------------
module sdram_stream_scheduler #(
   parameter int ADDR_W      = 12,
   parameter int BURST_WORDS = 512,
   parameter int FIFO_DEPTH  = 2048,
   parameter int USEDW_W     = 11
) (
   input  logic                sdram_clk,
   input  logic                reset_n,
   input  logic                refresh_req,
   output logic                refresh_ack,
   input  logic                wr_req,
   output logic                wr_grant,
   output logic                wr_stall,
   input  logic [USEDW_W-1:0]  fifo_wrusedw,
   output logic                cmd_valid,
   output logic [1:0]          cmd_op,
   output logic [ADDR_W-1:0]   cmd_addr,
   input  logic                cmd_done,
   output logic [ADDR_W:0]     ring_level,
   output logic                busy
);

   // State encoding equals the command opcode, so cmd_op is the state itself.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WRITE   = 2'b01,
      ST_READ    = 2'b10,
      ST_REFRESH = 2'b11
   } state_t;

   // A read is allowed only while a whole burst still fits into the FIFO.
   localparam int              RD_MAX_USED = FIFO_DEPTH - BURST_WORDS;
   localparam logic [ADDR_W:0] LEVEL_FULL  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LEVEL_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     level;

   // Arbitration looks only at registered copies of the request inputs.
   logic                refresh_req_q;
   logic                wr_req_q;
   logic [USEDW_W-1:0]  fifo_wrusedw_q;

   logic                wr_ok, rd_ok;

`ifndef SDRAM_SCHED_READ_PRIORITY_EN
   // 1 = the last data command granted was a READ. Reset value 1 makes the
   // first contested grant go to WRITE.
   logic                last_rd;
`endif

   // ---------------------------------------------------------------------
   // Input registers
   // ---------------------------------------------------------------------
   always_ff @(posedge sdram_clk or negedge reset_n) begin
      if (!reset_n) begin
         refresh_req_q  <= 1'b0;
         wr_req_q       <= 1'b0;
         fifo_wrusedw_q <= '0;
      end else begin
         refresh_req_q  <= refresh_req;
         wr_req_q       <= wr_req;
         fifo_wrusedw_q <= fifo_wrusedw;
      end
   end

   // ---------------------------------------------------------------------
   // Eligibility
   // ---------------------------------------------------------------------
   always_comb begin
      wr_ok = wr_req_q && (level != LEVEL_FULL);
      rd_ok = (level != '0) && (32'(fifo_wrusedw_q) <= RD_MAX_USED);
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge sdram_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (refresh_req_q) begin
               state_nxt = ST_REFRESH;
            end else if (wr_ok && rd_ok) begin
`ifdef SDRAM_SCHED_READ_PRIORITY_EN
               state_nxt = ST_READ;
`else
               state_nxt = last_rd ? ST_WRITE : ST_READ;
`endif
            end else if (wr_ok) begin
               state_nxt = ST_WRITE;
            end else if (rd_ok) begin
               state_nxt = ST_READ;
            end
         end
         // Command states hold until the engine finishes; a refresh_req that
         // drops mid-refresh does not abort it.
         ST_WRITE, ST_READ, ST_REFRESH: begin
            if (cmd_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Ring pointers and fill level. Updated only on completion of a data
   // command, so a stray cmd_done while idle changes nothing. Overflow and
   // underflow cannot occur because wr_ok/rd_ok gate command entry.
   // ---------------------------------------------------------------------
   always_ff @(posedge sdram_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (cmd_done) begin
         if (state == ST_WRITE) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            level  <= level + LEVEL_ONE;
         end else if (state == ST_READ) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            level  <= level - LEVEL_ONE;
         end
      end
   end

`ifndef SDRAM_SCHED_READ_PRIORITY_EN
   // Remember which data command was entered last for round-robin.
   always_ff @(posedge sdram_clk or negedge reset_n) begin
      if (!reset_n) begin
         last_rd <= 1'b1;
      end else if (state == ST_IDLE) begin
         if (state_nxt == ST_WRITE)     last_rd <= 1'b0;
         else if (state_nxt == ST_READ) last_rd <= 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Outputs. All decode from registers (plus cmd_done for the ack pulse),
   // so a reset mid-burst drops cmd_valid immediately.
   // ---------------------------------------------------------------------
   always_comb begin
      cmd_valid   = (state != ST_IDLE);
      cmd_op      = state;
      busy        = (state != ST_IDLE);
      wr_grant    = (state == ST_WRITE);
      refresh_ack = (state == ST_REFRESH) && cmd_done;
      wr_stall    = (level == LEVEL_FULL);
      ring_level  = level;
      case (state)
         ST_WRITE: cmd_addr = wr_ptr;
         ST_READ:  cmd_addr = rd_ptr;
         default:  cmd_addr = '0;
      endcase
   end

endmodule

// File: tb/tb_sdram_stream_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for sdram_stream_scheduler with a 4-burst ring (ADDR_W=2).
// Expected values are hand-derived; the two arbitration modes use separate
// expectation tables selected by SDRAM_SCHED_READ_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_sdram_stream_scheduler;

   localparam int AW = 2;

   logic              sdram_clk = 1'b0;
   logic              reset_n;
   logic              refresh_req;
   logic              refresh_ack;
   logic              wr_req;
   logic              wr_grant;
   logic              wr_stall;
   logic [10:0]       fifo_wrusedw;
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [AW-1:0]     cmd_addr;
   logic              cmd_done;
   logic [AW:0]       ring_level;
   logic              busy;

   int nchk  = 0;
   int npass = 0;

   always #5 sdram_clk = ~sdram_clk;

   sdram_stream_scheduler #(
      .ADDR_W(AW), .BURST_WORDS(512), .FIFO_DEPTH(2048), .USEDW_W(11)
   ) dut (
      .sdram_clk(sdram_clk), .reset_n(reset_n),
      .refresh_req(refresh_req), .refresh_ack(refresh_ack),
      .wr_req(wr_req), .wr_grant(wr_grant), .wr_stall(wr_stall),
      .fifo_wrusedw(fifo_wrusedw),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_done(cmd_done), .ring_level(ring_level), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Wait (bounded) for cmd_valid, then check the presented command.
   task automatic expect_cmd(input logic [1:0] op, input logic [31:0] addr, input string tag);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin
         @(negedge sdram_clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(cmd_valid), 1);
      chk({tag, "_op"},    32'(cmd_op), 32'(op));
      chk({tag, "_addr"},  32'(cmd_addr), addr);
      chk({tag, "_grant"}, 32'(wr_grant), 32'(op == 2'b01));
   endtask

   // Hold the command a few cycles, pulse cmd_done, check ack, level, idle gap.
   task automatic done_cmd(input logic ack_exp, input logic [31:0] lvl_exp, input string tag);
      repeat (3) @(negedge sdram_clk);
      cmd_done = 1'b1;
      #1;
      chk({tag, "_ack"}, 32'(refresh_ack), 32'(ack_exp));
      @(negedge sdram_clk);
      cmd_done = 1'b0;
      chk({tag, "_lvl"},  32'(ring_level), lvl_exp);
      chk({tag, "_idle"}, 32'(cmd_valid), 0);
   endtask

   logic [1:0]  rr_op  [4];
   logic [31:0] rr_addr[4];
   logic [31:0] rr_lvl [4];
   logic [31:0] ewp, elv, erp;

   initial begin
`ifdef SDRAM_SCHED_READ_PRIORITY_EN
      rr_op   = '{2'b10, 2'b10, 2'b01, 2'b10};
      rr_addr = '{2, 3, 0, 0};
      rr_lvl  = '{1, 0, 1, 0};
      ewp = 1; elv = 0; erp = 1;
`else
      rr_op   = '{2'b01, 2'b10, 2'b01, 2'b10};
      rr_addr = '{0, 2, 1, 3};
      rr_lvl  = '{3, 2, 3, 2};
      ewp = 2; elv = 2; erp = 0;
`endif

      reset_n = 1'b0; refresh_req = 1'b0; wr_req = 1'b0;
      cmd_done = 1'b0; fifo_wrusedw = 11'd2047;
      repeat (3) @(negedge sdram_clk);
      chk("rst_valid", 32'(cmd_valid), 0);
      chk("rst_op",    32'(cmd_op), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_level", 32'(ring_level), 0);
      chk("rst_stall", 32'(wr_stall), 0);
      chk("rst_grant", 32'(wr_grant), 0);
      chk("rst_ack",   32'(refresh_ack), 0);
      reset_n = 1'b1;

      // Writes: request registered on one edge, command on the next.
      @(negedge sdram_clk);
      wr_req = 1'b1;
      @(negedge sdram_clk);
      chk("lat_reg", 32'(cmd_valid), 0);
      @(negedge sdram_clk);
      chk("lat_cmd", 32'(cmd_valid), 1);
      chk("lat_busy", 32'(busy), 1);
      expect_cmd(2'b01, 0, "w0");
      done_cmd(1'b0, 1, "w0");
      // Held request reissues two cycles after cmd_done.
      @(negedge sdram_clk);
      chk("reissue", 32'(cmd_valid), 1);
      for (int i = 1; i < 4; i++) begin
         expect_cmd(2'b01, 32'(i), $sformatf("w%0d", i));
         done_cmd(1'b0, 32'(i + 1), $sformatf("w%0d", i));
      end
      chk("full_stall", 32'(wr_stall), 1);
      repeat (6) @(negedge sdram_clk);
      chk("full_nocmd", 32'(cmd_valid), 0);

      // Read threshold: 1537 used words blocks, 1536 allows.
      wr_req = 1'b0;
      fifo_wrusedw = 11'd1537;
      repeat (4) @(negedge sdram_clk);
      chk("rd_thresh_busy", 32'(busy), 0);
      fifo_wrusedw = 11'd1536;
      expect_cmd(2'b10, 0, "r0");
      done_cmd(1'b0, 3, "r0");
      chk("unstall", 32'(wr_stall), 0);
      expect_cmd(2'b10, 1, "r1");
      fifo_wrusedw = 11'd2047;
      done_cmd(1'b0, 2, "r1");

      // Both eligible: level 2, wr_ptr 0 (wrapped), rd_ptr 2.
      wr_req = 1'b1;
      fifo_wrusedw = 11'd1536;
      for (int k = 0; k < 4; k++) begin
         expect_cmd(rr_op[k], rr_addr[k], $sformatf("arb%0d", k));
         if (k == 3) begin
            wr_req = 1'b0;
            fifo_wrusedw = 11'd2047;
         end
         done_cmd(1'b0, rr_lvl[k], $sformatf("arb%0d", k));
      end

      // Refresh raised during a write: write finishes, refresh next, then write.
      wr_req = 1'b1;
      expect_cmd(2'b01, ewp, "pre_rf");
      refresh_req = 1'b1;
      done_cmd(1'b0, elv + 1, "pre_rf");
      expect_cmd(2'b11, 0, "rf");
      refresh_req = 1'b0;
      repeat (3) @(negedge sdram_clk);
      chk("rf_hold_valid", 32'(cmd_valid), 1);
      chk("rf_hold_op",    32'(cmd_op), 3);
      done_cmd(1'b1, elv + 1, "rf");
      expect_cmd(2'b01, ewp + 1, "post_rf");
      wr_req = 1'b0;
      done_cmd(1'b0, elv + 2, "post_rf");

      // Reset in the middle of a read burst.
      fifo_wrusedw = 11'd1536;
      expect_cmd(2'b10, erp, "rst_rd");
      @(posedge sdram_clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_valid", 32'(cmd_valid), 0);
      chk("abort_level", 32'(ring_level), 0);
      chk("abort_busy",  32'(busy), 0);
      @(negedge sdram_clk);
      fifo_wrusedw = 11'd2047;
      reset_n = 1'b1;
      @(negedge sdram_clk);
      cmd_done = 1'b1;
      @(negedge sdram_clk);
      cmd_done = 1'b0;
      chk("stray_level", 32'(ring_level), 0);
      chk("stray_valid", 32'(cmd_valid), 0);
      wr_req = 1'b1;
      expect_cmd(2'b01, 0, "post_rst");
      wr_req = 1'b0;
      done_cmd(1'b0, 1, "post_rst");

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
